// File: rtl/ofm_tile_scheduler.sv
// Layer sequencer for the OFM read controller: one start, then one load per tile.
// Optional tile watchdog enabled by defining TILE_WDT_EN.
module ofm_tile_scheduler #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int OFM_RAM_SIZE  = 2378675,
  parameter int WDT_CYCLES    = 4096,
  localparam int AW = $clog2(OFM_RAM_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          layer_start,
  input  logic [AW-1:0] start_read_addr,
  input  logic [8:0]    ifm_size,
  input  logic [10:0]   ifm_channel,
  input  logic [1:0]    kernel_size,
  input  logic [8:0]    ofm_size,
  input  logic          tile_done,
  input  logic          sys_ready,
  output logic          start,
  output logic [AW-1:0] rd_start_addr,
  output logic          load,
  output logic          busy,
  output logic [8:0]    row_idx,
  output logic [4:0]    strip_idx,
  output logic          layer_done,
  output logic          wdt_err
);

  localparam int SH = $clog2(SYSTOLIC_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    START,
    GAP,
    WAIT_READY,
    ISSUE,
    WAIT_DONE,
    LAYER_DONE
  } state_t;

  state_t state, state_n;

  logic [AW-1:0] addr_q;
  logic [8:0]    ofm_q;
  logic [8:0]    ifm_q;
  logic [10:0]   ch_q;
  logic [1:0]    ks_q;
  logic [5:0]    nstrip_q;
  logic [8:0]    row_q;
  logic [4:0]    strip_q;

  logic [9:0]    strip_sum;
  logic [9:0]    strip_cnt;
  logic          row_last;
  logic          strip_last;
  logic          tile_last;
  logic          wdt_trip;

  // ceil(ofm_size / SYSTOLIC_SIZE) without a divider
  assign strip_sum = {1'b0, ofm_size} + 10'(SYSTOLIC_SIZE - 1);
  assign strip_cnt = strip_sum >> SH;

  assign row_last   = (row_q == ofm_q - 9'd1);
  assign strip_last = ({1'b0, strip_q} == nstrip_q - 6'd1);
  assign tile_last  = row_last && strip_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      ofm_q    <= '0;
      ifm_q    <= '0;
      ch_q     <= '0;
      ks_q     <= '0;
      nstrip_q <= '0;
      row_q    <= '0;
      strip_q  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && layer_start) begin
        addr_q   <= start_read_addr;
        ofm_q    <= ofm_size;
        ifm_q    <= ifm_size;
        ch_q     <= ifm_channel;
        ks_q     <= kernel_size;
        nstrip_q <= strip_cnt[5:0];
        row_q    <= '0;
        strip_q  <= '0;
      end
      if (state == WAIT_DONE && tile_done) begin
        if (row_last) begin
          row_q   <= '0;
          strip_q <= strip_q + 5'd1;
        end else begin
          row_q <= row_q + 9'd1;
        end
      end
    end
  end

  always_comb begin
    state_n    = state;
    start      = 1'b0;
    load       = 1'b0;
    layer_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (layer_start)
          state_n = (ofm_size == 9'd0) ? LAYER_DONE : START;
      end
      START: begin
        start   = 1'b1;
        state_n = GAP;
      end
      GAP: state_n = WAIT_READY;
      WAIT_READY: begin
        if (sys_ready) state_n = ISSUE;
      end
      ISSUE: begin
        load    = 1'b1;
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tile_done)
          state_n = tile_last ? LAYER_DONE : GAP;
        else if (wdt_trip)
          state_n = LAYER_DONE;
      end
      LAYER_DONE: begin
        layer_done = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef TILE_WDT_EN
  logic [12:0] wdt_cnt;
  logic        wdt_q;

  // wdt_cnt holds the number of cycles since the load pulse
  assign wdt_trip = (state == WAIT_DONE) &&
                    (wdt_cnt == 13'(WDT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt <= '0;
      wdt_q   <= 1'b0;
    end else begin
      if (state == ISSUE)
        wdt_cnt <= 13'd1;
      else if (state == WAIT_DONE)
        wdt_cnt <= wdt_cnt + 13'd1;
      if (wdt_trip && !tile_done)
        wdt_q <= 1'b1;
    end
  end

  assign wdt_err = wdt_q;
`else
  assign wdt_trip = 1'b0;
  assign wdt_err  = 1'b0;
`endif

  logic unused_cfg;
  assign unused_cfg = ^{ifm_q, ch_q, ks_q, 13'(WDT_CYCLES)};

  assign busy          = (state != IDLE);
  assign rd_start_addr = addr_q;
  assign row_idx       = row_q;
  assign strip_idx     = strip_q;

endmodule
